// File: rtl/pipearch_dma_read_arbiter_pkg.sv
// Payload types shared by the DMA read arbiter, its clients and the DMA engine.
package pipearch_dma_read_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned DATA_W = 64;

    // Transfer request towards a DMA engine; start is a one-cycle pulse.
    typedef struct packed {
        logic              start;
        logic              async;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  length;
    } t_dma_control;

    // Transfer progress reported back by a DMA engine.
    typedef struct packed {
        logic idle;
        logic active;
        logic done;
    } t_dma_status;

    // Read-enable from the consumer side of a read stream.
    typedef struct packed {
        logic re;
    } t_dma_tx_read;

    // Read data towards the consumer side of a read stream.
    typedef struct packed {
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
        logic              ralmostfull;
    } t_dma_rx_read;

endpackage

// File: rtl/pipearch_dma_read_arbiter.sv
// Round-robin arbiter sharing one DMA read engine among NUM_CLIENTS read ports.
// A grant covers a whole transfer, from the issued start pulse until the engine
// reports done. Optional macro PIPEARCH_ARB_PRIO0_EN gives client 0 strict
// priority, with round-robin among the remaining clients.
module pipearch_dma_read_arbiter
    import pipearch_dma_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS      = 4,
    parameter int unsigned LOG2_NUM_CLIENTS = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  t_dma_control                client_control [NUM_CLIENTS],
    output t_dma_status                 client_status  [NUM_CLIENTS],
    input  t_dma_tx_read                client_tx_read [NUM_CLIENTS],
    output t_dma_rx_read                client_rx_read [NUM_CLIENTS],
    output t_dma_control                dma_control,
    input  t_dma_status                 dma_status,
    output t_dma_tx_read                dma_tx_read,
    input  t_dma_rx_read                dma_rx_read,
    output logic                        grant_valid,
    output logic [LOG2_NUM_CLIENTS-1:0] grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } t_state;

    t_state                      state;
    logic [NUM_CLIENTS-1:0]      pending;
    logic [NUM_CLIENTS-1:0]      done_q;
    t_dma_control                req_q [NUM_CLIENTS];
    logic [LOG2_NUM_CLIENTS-1:0] last_grant;

    logic [NUM_CLIENTS-1:0]      accept;
    logic [NUM_CLIENTS-1:0]      done_hit;
    logic                        next_found;
    logic [LOG2_NUM_CLIENTS-1:0] next_grant;
    logic [LOG2_NUM_CLIENTS-1:0] arb_idx;
    t_dma_control                issue_ctrl;

    // Engine idle/active are informational only; completion is tracked via done.
    logic unused_status;
    assign unused_status = &{1'b0, dma_status.idle, dma_status.active};

    // Per-client request capture: a start is taken only when the client has
    // nothing outstanding, or in the very cycle its current transfer completes.
    always_comb begin
        accept   = '0;
        done_hit = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            done_hit[i] = (state == ST_BUSY) && dma_status.done &&
                          (grant_id == LOG2_NUM_CLIENTS'(i));
            accept[i]   = client_control[i].start && (!pending[i] || done_hit[i]);
        end
    end

    // Pending flags and latched requests; a new accept overrides completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                req_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (accept[i]) begin
                    pending[i] <= 1'b1;
                    req_q[i]   <= client_control[i];
                end else if (done_hit[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Next owner: first pending client after last_grant, wrapping modulo N.
    always_comb begin
        next_found = 1'b0;
        next_grant = '0;
        arb_idx    = '0;
`ifdef PIPEARCH_ARB_PRIO0_EN
        if (pending[0]) begin
            next_found = 1'b1;
            next_grant = '0;
        end
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            arb_idx = LOG2_NUM_CLIENTS'((32'(last_grant) + k) % NUM_CLIENTS);
            if (!next_found && (arb_idx != '0) && pending[arb_idx]) begin
                next_found = 1'b1;
                next_grant = arb_idx;
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            arb_idx = LOG2_NUM_CLIENTS'((32'(last_grant) + k) % NUM_CLIENTS);
            if (!next_found && pending[arb_idx]) begin
                next_found = 1'b1;
                next_grant = arb_idx;
            end
        end
`endif
    end

    // Request presented to the engine on the issue cycle.
    always_comb begin
        issue_ctrl       = req_q[next_grant];
        issue_ctrl.start = 1'b1;
    end

    // Grant FSM: IDLE picks an owner, ISSUE pulses start, BUSY waits for done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            last_grant  <= LOG2_NUM_CLIENTS'(NUM_CLIENTS - 1);
            dma_control <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            done_q      <= '0;
        end else begin
            done_q <= done_hit;
            case (state)
                ST_IDLE: begin
                    if (next_found) begin
                        state       <= ST_ISSUE;
                        grant_id    <= next_grant;
                        last_grant  <= next_grant;
                        grant_valid <= 1'b1;
                        dma_control <= issue_ctrl;
                    end
                end
                ST_ISSUE: begin
                    state             <= ST_BUSY;
                    dma_control.start <= 1'b0;
                end
                ST_BUSY: begin
                    if (dma_status.done) begin
                        state       <= ST_IDLE;
                        grant_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    // Per-client status decoded from pending, ownership and the done pulse.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client_status[i].active = grant_valid && (grant_id == LOG2_NUM_CLIENTS'(i));
            client_status[i].idle   = !pending[i] && !client_status[i].active;
            client_status[i].done   = done_q[i];
        end
    end

    // Zero-latency data routing between the owning client and the engine.
    always_comb begin
        dma_tx_read = '0;
        if (grant_valid) begin
            dma_tx_read = client_tx_read[grant_id];
        end
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client_rx_read[i].rvalid      = 1'b0;
            client_rx_read[i].rdata       = '0;
            client_rx_read[i].ralmostfull = 1'b1;
            if (grant_valid && (grant_id == LOG2_NUM_CLIENTS'(i))) begin
                client_rx_read[i] = dma_rx_read;
            end
        end
    end

endmodule

// File: tb/tb_pipearch_dma_read_arbiter.sv
// Self-checking bench for pipearch_dma_read_arbiter: the bench plays the DMA
// engine and the clients, and predicts grant order from a pending-set model.
module tb_pipearch_dma_read_arbiter;
    import pipearch_dma_read_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned LG = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    t_dma_control cc  [N];
    t_dma_status  cs  [N];
    t_dma_tx_read ctx [N];
    t_dma_rx_read crx [N];
    t_dma_control dctl;
    t_dma_status  dst;
    t_dma_tx_read dtx;
    t_dma_rx_read drx;
    logic         gv;
    logic [LG-1:0] gid;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last;

    always #5 clk = ~clk;

    pipearch_dma_read_arbiter #(.NUM_CLIENTS(N), .LOG2_NUM_CLIENTS(LG)) dut (
        .clk(clk), .reset_n(reset_n),
        .client_control(cc), .client_status(cs),
        .client_tx_read(ctx), .client_rx_read(crx),
        .dma_control(dctl), .dma_status(dst),
        .dma_tx_read(dtx), .dma_rx_read(drx),
        .grant_valid(gv), .grant_id(gid)
    );

    function automatic t_dma_status mk_status(input logic idle, input logic active, input logic done);
        t_dma_status s;
        s.idle = idle; s.active = active; s.done = done;
        return s;
    endfunction

    function automatic t_dma_rx_read quiet_rx();
        t_dma_rx_read r;
        r.rvalid = 1'b0; r.rdata = '0; r.ralmostfull = 1'b1;
        return r;
    endfunction

    // Which pending client the spec's arbitration rule picks next.
    function automatic int model_pick(input logic [N-1:0] m, input int last);
        int c;
`ifdef PIPEARCH_ARB_PRIO0_EN
        if (m[0]) return 0;
        for (int k = 1; k <= int'(N); k++) begin
            c = (last + k) % int'(N);
            if (c != 0 && m[c]) return c;
        end
`else
        for (int k = 1; k <= int'(N); k++) begin
            c = (last + k) % int'(N);
            if (m[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < int'(N); i++) begin
            cc[i]  = '0;
            ctx[i] = '0;
        end
        dst = '0;
        drx = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        m_last = int'(N) - 1;
    endtask

    // Bounded wait for the engine start pulse; ticks counts cycles advanced.
    task automatic wait_start(input int limit, output int ticks, output bit seen);
        ticks = 0;
        seen  = 1'b0;
        while (!seen && ticks <= limit) begin
            if (dctl.start === 1'b1) seen = 1'b1;
            else begin
                tick();
                ticks++;
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #3;
        n_cmp++; if (gv !== 1'b0) begin n_bad++; $display("FAIL reset_grant_valid got=%b want=0", gv); end
        n_cmp++; if (gid !== '0) begin n_bad++; $display("FAIL reset_grant_id got=%0d want=0", gid); end
        n_cmp++; if (dctl !== '0) begin n_bad++; $display("FAIL reset_dma_control got=%h want=0", dctl); end
        n_cmp++; if (dtx !== '0) begin n_bad++; $display("FAIL reset_dma_tx_read got=%h want=0", dtx); end
        for (int i = 0; i < int'(N); i++) begin
            n_cmp++; if (cs[i] !== mk_status(1'b1, 1'b0, 1'b0)) begin n_bad++; $display("FAIL reset_status[%0d] got=%b want=100", i, cs[i]); end
            n_cmp++; if (crx[i] !== quiet_rx()) begin n_bad++; $display("FAIL reset_rx[%0d] got=%h want=%h", i, crx[i], quiet_rx()); end
        end
        tick();
        reset_n = 1'b1;
        tick();
        m_last = int'(N) - 1;
    endtask

    task automatic test_single();
        t_dma_control exp;
        exp.start = 1'b1; exp.async = 1'b1; exp.addr = 32'h100; exp.length = 16'd8;
        cc[1] = exp;
        tick();
        cc[1] = '0;
        n_cmp++; if (dctl.start !== 1'b0) begin n_bad++; $display("FAIL single_cyc1_start got=%b want=0", dctl.start); end
        n_cmp++; if (cs[1] !== mk_status(1'b0, 1'b0, 1'b0)) begin n_bad++; $display("FAIL single_cyc1_status got=%b want=000", cs[1]); end
        tick();
        n_cmp++; if (dctl !== exp) begin n_bad++; $display("FAIL single_cyc2_ctrl got=%h want=%h", dctl, exp); end
        n_cmp++; if (gid !== 2'd1 || gv !== 1'b1) begin n_bad++; $display("FAIL single_grant got=%b/%0d want=1/1", gv, gid); end
        n_cmp++; if (cs[1] !== mk_status(1'b0, 1'b1, 1'b0)) begin n_bad++; $display("FAIL single_active got=%b want=010", cs[1]); end
        tick();
        tick();
        exp.start = 1'b0;
        n_cmp++; if (dctl !== exp) begin n_bad++; $display("FAIL single_busy_ctrl got=%h want=%h", dctl, exp); end
        dst.done = 1'b1;
        tick();
        dst.done = 1'b0;
        n_cmp++; if (cs[1] !== mk_status(1'b1, 1'b0, 1'b1)) begin n_bad++; $display("FAIL single_done_pulse got=%b want=101", cs[1]); end
        n_cmp++; if (gv !== 1'b0) begin n_bad++; $display("FAIL single_release got=%b want=0", gv); end
        tick();
        n_cmp++; if (cs[1] !== mk_status(1'b1, 1'b0, 1'b0)) begin n_bad++; $display("FAIL single_done_end got=%b want=100", cs[1]); end
        m_last = 1;
    endtask

    // Clients in mask start together; each grant is served with random data
    // traffic, optional duplicate starts and an ignored done during ISSUE.
    task automatic test_batch(input logic [N-1:0] mask, input bit dup);
        logic [N-1:0] m;
        t_dma_control exp_req [N];
        t_dma_control exp;
        int g, ticks, nb, j;
        bit seen;
        m = mask;
        for (int i = 0; i < int'(N); i++) begin
            exp_req[i] = '0;
            if (mask[i]) begin
                cc[i].start  = 1'b1;
                cc[i].async  = 1'($urandom_range(0, 1));
                cc[i].addr   = $urandom;
                cc[i].length = 16'($urandom);
                exp_req[i]   = cc[i];
            end
        end
        tick();
        for (int i = 0; i < int'(N); i++) cc[i].start = 1'b0;
        while (m != '0) begin
            g = model_pick(m, m_last);
            wait_start(8, ticks, seen);
            n_cmp++; if (!seen) begin n_bad++; $display("FAIL batch_issue_timeout got=none want=client%0d", g); break; end
            n_cmp++; if (ticks != 1) begin n_bad++; $display("FAIL batch_issue_latency got=%0d want=1", ticks); end
            n_cmp++; if (int'(gid) != g || gv !== 1'b1) begin n_bad++; $display("FAIL batch_grant got=%b/%0d want=1/%0d", gv, gid, g); end
            exp = exp_req[g];
            exp.start = 1'b1;
            n_cmp++; if (dctl !== exp) begin n_bad++; $display("FAIL batch_issue_ctrl got=%h want=%h", dctl, exp); end
            if (dup) dst.done = 1'($urandom_range(0, 1));
            exp.start = 1'b0;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                tick();
                dst.done = 1'b0;
                for (int i = 0; i < int'(N); i++) cc[i].start = 1'b0;
                n_cmp++; if (dctl !== exp || gv !== 1'b1) begin n_bad++; $display("FAIL batch_busy_ctrl got=%h/%b want=%h/1", dctl, gv, exp); end
                for (int i = 0; i < int'(N); i++) begin
                    n_cmp++; if (cs[i] !== mk_status(!m[i], i == g, 1'b0)) begin n_bad++; $display("FAIL batch_status[%0d] got=%b want=%b", i, cs[i], mk_status(!m[i], i == g, 1'b0)); end
                    ctx[i].re = 1'($urandom_range(0, 1));
                end
                drx.rvalid = 1'($urandom_range(0, 1));
                drx.rdata = {$urandom, $urandom};
                drx.ralmostfull = 1'($urandom_range(0, 1));
                #1;
                n_cmp++; if (dtx.re !== ctx[g].re) begin n_bad++; $display("FAIL batch_tx_route got=%b want=%b", dtx.re, ctx[g].re); end
                for (int i = 0; i < int'(N); i++) begin
                    n_cmp++; if (crx[i] !== ((i == g) ? drx : quiet_rx())) begin n_bad++; $display("FAIL batch_rx_route[%0d] got=%h want=%h", i, crx[i], (i == g) ? drx : quiet_rx()); end
                end
                if (dup) begin
                    j = $urandom_range(0, int'(N) - 1);
                    if (m[j]) begin
                        cc[j].start = 1'b1;
                        cc[j].addr  = $urandom;
                    end
                end
            end
            tick();
            for (int i = 0; i < int'(N); i++) begin
                cc[i].start = 1'b0;
                ctx[i] = '0;
            end
            drx = '0;
            dst.done = 1'b1;
            tick();
            dst.done = 1'b0;
            m[g] = 1'b0;
            m_last = g;
            n_cmp++; if (cs[g] !== mk_status(1'b1, 1'b0, 1'b1) || gv !== 1'b0) begin n_bad++; $display("FAIL batch_done got=%b/%b want=101/0", cs[g], gv); end
        end
        tick();
        n_cmp++; if (cs[m_last].done !== 1'b0 || dctl.start !== 1'b0) begin n_bad++; $display("FAIL batch_quiet got=%b/%b want=0/0", cs[m_last].done, dctl.start); end
    endtask

    task automatic test_round_robin();
        do_reset();
        test_batch(4'b1101, 1'b0);
        test_batch(4'b0011, 1'b0);
    endtask

    task automatic test_done_restart();
        int ticks;
        bit seen;
        cc[2].start = 1'b1; cc[2].addr = 32'hA000; cc[2].length = 16'd4;
        tick();
        cc[2].start = 1'b0;
        wait_start(8, ticks, seen);
        n_cmp++; if (!seen || gid !== 2'd2) begin n_bad++; $display("FAIL restart_first got=%b/%0d want=1/2", seen, gid); end
        tick();
        tick();
        dst.done = 1'b1;
        cc[2].start = 1'b1; cc[2].addr = 32'hB000;
        tick();
        dst.done = 1'b0;
        cc[2].start = 1'b0;
        n_cmp++; if (cs[2] !== mk_status(1'b0, 1'b0, 1'b1) || gv !== 1'b0) begin n_bad++; $display("FAIL restart_done got=%b/%b want=001/0", cs[2], gv); end
        wait_start(8, ticks, seen);
        n_cmp++; if (!seen || ticks != 1) begin n_bad++; $display("FAIL restart_latency got=%b/%0d want=1/1", seen, ticks); end
        n_cmp++; if (dctl.addr !== 32'hB000 || gid !== 2'd2) begin n_bad++; $display("FAIL restart_second got=%h/%0d want=b000/2", dctl.addr, gid); end
        tick();
        dst.done = 1'b1;
        tick();
        dst.done = 1'b0;
        tick();
        m_last = 2;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            test_batch(N'($urandom_range(1, (1 << N) - 1)), 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int ticks;
        bit seen;
        cc[3].start = 1'b1; cc[3].addr = 32'h3300; cc[3].length = 16'd2;
        tick();
        cc[3].start = 1'b0;
        wait_start(8, ticks, seen);
        tick();
        tick();
        ctx[3].re = 1'b1;
        #1;
        n_cmp++; if (dtx.re !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_route got=%b want=1", dtx.re); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (gv !== 1'b0 || gid !== '0) begin n_bad++; $display("FAIL midrst_grant got=%b/%0d want=0/0", gv, gid); end
        n_cmp++; if (dctl !== '0 || dtx !== '0) begin n_bad++; $display("FAIL midrst_dma got=%h/%h want=0/0", dctl, dtx); end
        for (int i = 0; i < int'(N); i++) begin
            n_cmp++; if (cs[i] !== mk_status(1'b1, 1'b0, 1'b0) || crx[i] !== quiet_rx()) begin n_bad++; $display("FAIL midrst_client[%0d] got=%b/%h want=100/%h", i, cs[i], crx[i], quiet_rx()); end
        end
        ctx[3].re = 1'b0;
        tick();
        reset_n = 1'b1;
        m_last = int'(N) - 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (dctl.start !== 1'b0 || gv !== 1'b0) begin n_bad++; $display("FAIL midrst_no_issue got=%b/%b want=0/0", dctl.start, gv); end
        end
    endtask

    task automatic test_prio();
        do_reset();
        test_batch(4'b0001, 1'b0);
        test_batch(4'b1001, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        m_last  = int'(N) - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_done_restart();
        test_random();
        test_reset_mid();
        test_prio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
